// File: rtl/intra_sched.sv
`default_nettype none
// ============================================================================
//  Module   : intra_sched
//  Purpose  : Frame-level sequencer for the intra-prediction residue path.
//             Walks every 4x4 block of a LENGTH x WIDTH frame in raster
//             order. For each block it starts the predictor, scans the
//             eight mode SADs serially to pick the best mode, streams that
//             mode's 16 residues to the residue frame buffer with pixel
//             addresses, and records the chosen mode in the mode table.
//  Ports    :
//    clk         rising-edge clock
//    reset       asynchronous active-low reset
//    start       begin a frame (honoured only while idle)
//    busy        high whenever the sequencer is not idle
//    frame_done  one-cycle pulse after the last block is written
//    pred_start  one-cycle pulse, predictor begins block pred_blk
//    pred_blk    current block number
//    pred_done   predictor results valid (held until next pred_start)
//    sad_idx     mode whose SAD is being read; sad_in is its SAD
//    res_mode    chosen mode, stable throughout the write phase
//    res_idx     residue index k = 4*i + j; res_in is that residue
//    wr_en       residue write request, accepted when wr_ready is high
//    wr_addr     pixel address of the residue beat
//    wr_data     residue beat (pass-through of res_in)
//    mode_we     mode-table write strobe
//    mode_addr   mode-table address (block number)
//    mode_data   mode-table data (chosen mode)
//  Revision : 1.0  initial release
// ============================================================================
module intra_sched #(
  parameter int LENGTH = 256,
  parameter int WIDTH  = 256,
  localparam int c_nblk = (LENGTH / 4) * (WIDTH / 4),
  localparam int c_bw   = $clog2(c_nblk),
  localparam int c_aw   = $clog2(LENGTH * WIDTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            frame_done,
  output logic            pred_start,
  output logic [c_bw-1:0] pred_blk,
  input  logic            pred_done,
  output logic [2:0]      sad_idx,
  input  logic [11:0]     sad_in,
  output logic [2:0]      res_mode,
  output logic [3:0]      res_idx,
  input  logic [7:0]      res_in,
  output logic            wr_en,
  output logic [c_aw-1:0] wr_addr,
  output logic [7:0]      wr_data,
  input  logic            wr_ready,
  output logic            mode_we,
  output logic [c_bw-1:0] mode_addr,
  output logic [2:0]      mode_data
);

  // Number of block-column bits: a block number splits into {row, col}.
  localparam int             c_cb       = $clog2(WIDTH / 4);
  localparam logic [c_bw-1:0] c_last_blk = c_bw'(c_nblk - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRED  = 3'd1,
    S_CMP   = 3'd2,
    S_WRITE = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_pred_start;
  logic            r_mode_we;
  logic [c_bw-1:0] r_blk;
  logic [2:0]      r_sad_idx;
  logic [11:0]     r_best_sad;
  logic [2:0]      r_best_mode;
  logic [2:0]      r_res_mode;
  logic [3:0]      r_res_idx;

  logic            w_beat;
  logic            w_better;

  assign w_beat   = (r_state == S_WRITE) && wr_ready;
  // Strict compare: on a tie the earlier (lower) mode index is kept.
  assign w_better = (sad_in < r_best_sad);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_PRED;
      S_PRED:  if (pred_done) w_next = S_CMP;
      S_CMP:   if (r_sad_idx == 3'd7) w_next = S_WRITE;
      S_WRITE: if (w_beat && (r_res_idx == 4'd15)) w_next = S_NEXT;
      S_NEXT:  w_next = (r_blk == c_last_blk) ? S_DONE : S_PRED;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pred_start <= 1'b0;
      r_mode_we    <= 1'b0;
      r_blk        <= '0;
      r_sad_idx    <= 3'd0;
      r_best_sad   <= 12'd0;
      r_best_mode  <= 3'd0;
      r_res_mode   <= 3'd0;
      r_res_idx    <= 4'd0;
    end else begin
      // Strobes mark the first cycle of their state; registering them on
      // the transition keeps every output free of input-to-output paths.
      r_pred_start <= (w_next == S_PRED)  && (r_state != S_PRED);
      r_mode_we    <= (w_next == S_WRITE) && (r_state != S_WRITE);

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_blk <= '0;
          end
        end
        S_CMP: begin
          // Wraps 7 -> 0, leaving the index ready for the next block.
          r_sad_idx <= r_sad_idx + 3'd1;
          if ((r_sad_idx == 3'd0) || w_better) begin
            r_best_sad  <= sad_in;
            r_best_mode <= r_sad_idx;
          end
          if (r_sad_idx == 3'd7) begin
            r_res_mode <= w_better ? 3'd7 : r_best_mode;
          end
        end
        S_WRITE: begin
          // Wraps 15 -> 0 on the final accepted beat.
          if (w_beat) begin
            r_res_idx <= r_res_idx + 4'd1;
          end
        end
        S_NEXT: begin
          if (r_blk != c_last_blk) begin
            r_blk <= r_blk + c_bw'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);
  assign wr_en      = (r_state == S_WRITE);
  assign pred_start = r_pred_start;
  assign pred_blk   = r_blk;
  assign sad_idx    = r_sad_idx;
  assign res_mode   = r_res_mode;
  assign res_idx    = r_res_idx;
  assign mode_we    = r_mode_we;
  assign mode_addr  = r_blk;
  assign mode_data  = r_res_mode;
  assign wr_data    = res_in;

  // With power-of-two dimensions the pixel address
  //   (4*row + i)*WIDTH + 4*col + j
  // is a plain bit concatenation {row, i, col, j}.
  assign wr_addr = {r_blk[c_bw-1:c_cb], r_res_idx[3:2],
                    r_blk[c_cb-1:0],    r_res_idx[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_intra_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_intra_sched
//  Purpose  : Self-checking bench for intra_sched on an 8x8 frame (4 blocks).
//             A predictor model serves per-block SAD vectors and residues; a
//             scoreboard holds the expected writes and mode-table entries.
//  Revision : 1.0  initial release
// ============================================================================
module tb_intra_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic        pred_start;
  logic [1:0]  pred_blk;
  logic        pred_done;
  logic [2:0]  sad_idx;
  logic [11:0] sad_in;
  logic [2:0]  res_mode;
  logic [3:0]  res_idx;
  logic [7:0]  res_in;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        mode_we;
  logic [1:0]  mode_addr;
  logic [2:0]  mode_data;

  intra_sched #(.LENGTH(8), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .frame_done(frame_done), .pred_start(pred_start), .pred_blk(pred_blk),
    .pred_done(pred_done), .sad_idx(sad_idx), .sad_in(sad_in),
    .res_mode(res_mode), .res_idx(res_idx), .res_in(res_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .mode_we(mode_we), .mode_addr(mode_addr),
    .mode_data(mode_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // --------------------------------------------------------------------------
  // Stimulus table
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0][11:0] sad;
    logic [3:0]       d;     // pred_done delay after pred_start
    logic             bp;    // stall wr_ready 3 cycles at k=5
    logic [2:0]       mode;  // expected winning mode
  } vec_t;

  typedef struct packed {
    logic [5:0] a;
    logic [7:0] d;
  } wexp_t;

  vec_t  vecs [8];
  vec_t  cur_vec;
  int    cur_blk  = 0;
  int    cur_salt = 0;
  wexp_t wq [$];
  logic [4:0] mq [$];

  int n_vec  = 0;
  int n_fail = 0;

  function automatic vec_t mkv(input int s0, input int s1, input int s2,
                               input int s3, input int s4, input int s5,
                               input int s6, input int s7, input int d,
                               input bit bp, input int m);
    vec_t v;
    v.sad[0] = 12'(s0); v.sad[1] = 12'(s1); v.sad[2] = 12'(s2);
    v.sad[3] = 12'(s3); v.sad[4] = 12'(s4); v.sad[5] = 12'(s5);
    v.sad[6] = 12'(s6); v.sad[7] = 12'(s7);
    v.d    = 4'(d);
    v.bp   = bp;
    v.mode = 3'(m);
    return v;
  endfunction

  function automatic logic [7:0] resval(input int b, input logic [2:0] m,
                                        input logic [3:0] k, input int s);
    int t;
    t = b * 53 + int'(m) * 16 + int'(k) + s;
    return t[7:0];
  endfunction

  function automatic logic [5:0] eaddr(input int b, input int k);
    int br, bc, i, j, a;
    br = b / 2; bc = b % 2; i = k / 4; j = k % 4;
    a  = (4 * br + i) * 8 + 4 * bc + j;
    return a[5:0];
  endfunction

  assign sad_in = cur_vec.sad[sad_idx];
  assign res_in = resval(cur_blk, res_mode, res_idx, cur_salt);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor / predictor model / scoreboard
  // --------------------------------------------------------------------------
  bit         sb_on       = 1'b0;
  int         fb          = 0;
  int         exp_blk     = 0;
  int         frame_sum   = 0;
  int         frame_ps    = 0;
  int         last_ps     = 0;
  int         last_period = 0;
  int         cmp_chk_cyc = -1;
  int         pd_left     = 0;
  int         stall_left  = 0;
  bit         bp_armed    = 1'b0;
  bit         prev_stall  = 1'b0;
  logic [5:0] held_addr;
  logic [7:0] held_data;
  logic [63:0] seen;
  int         ndist = 0;
  int         n_fd  = 0;

  initial begin
    vec_t  v;
    wexp_t w;
    logic [4:0] me;
    forever begin
      @(negedge clk);
      if (!reset || !sb_on) begin
        wr_ready   = 1'b1;
        pred_done  = 1'b0;
        stall_left = 0;
        prev_stall = 1'b0;
      end else begin
        if (pred_start) begin
          if (exp_blk > 3) begin
            chk("extra_pred_start", exp_blk, 3);
          end else begin
            chk("pred_blk", pred_blk, exp_blk);
            if (exp_blk > 0) chk("block_period", cyc - last_ps, last_period);
            else frame_ps = cyc;
            v        = vecs[fb + exp_blk];
            cur_vec  = v;
            cur_blk  = exp_blk;
            mq.push_back({exp_blk[1:0], v.mode});
            for (int k = 0; k < 16; k++) begin
              w.a = eaddr(exp_blk, k);
              w.d = resval(exp_blk, v.mode, 4'(k), cur_salt);
              wq.push_back(w);
            end
            last_ps     = cyc;
            last_period = int'(v.d) + 26 + (v.bp ? 3 : 0);
            frame_sum  += last_period;
            cmp_chk_cyc = cyc + int'(v.d) + 2;
            pd_left     = int'(v.d);
            bp_armed    = v.bp;
            exp_blk++;
          end
        end
        // CMP must start exactly d+1 cycles after pred_start.
        if (cyc == cmp_chk_cyc) chk("cmp_start_idx", sad_idx, 1);

        if (pd_left == 0) pred_done = 1'b1;
        else begin
          pred_done = 1'b0;
          pd_left--;
        end

        if (prev_stall) begin
          chk("bp_hold_addr", wr_addr, held_addr);
          chk("bp_hold_data", wr_data, held_data);
        end
        if (wr_en && bp_armed && (res_idx == 4'd5)) begin
          stall_left = 3;
          bp_armed   = 1'b0;
        end
        if (stall_left > 0) begin
          wr_ready = 1'b0;
          stall_left--;
        end else begin
          wr_ready = 1'b1;
        end
        prev_stall = wr_en && !wr_ready;
        held_addr  = wr_addr;
        held_data  = wr_data;

        if (wr_en && wr_ready) begin
          chk("write_expected", wq.size() != 0, 1);
          if (wq.size() != 0) begin
            w = wq.pop_front();
            chk("wr_addr", wr_addr, w.a);
            chk("wr_data", wr_data, w.d);
          end
          if (!seen[wr_addr]) ndist++;
          seen[wr_addr] = 1'b1;
        end
        if (mode_we) begin
          chk("mode_expected", mq.size() != 0, 1);
          if (mq.size() != 0) begin
            me = mq.pop_front();
            chk("mode_addr", mode_addr, me[4:3]);
            chk("mode_data", mode_data, me[2:0]);
          end
        end
        if (frame_done) begin
          n_fd++;
          chk("frame_latency", cyc - frame_ps, frame_sum);
          chk("distinct_addrs", ndist, 64);
          chk("blocks_started", exp_blk, 4);
          chk("sb_drained", wq.size() + mq.size(), 0);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequences
  // --------------------------------------------------------------------------
  task automatic run_frame(input int f, input bit poke_busy,
                           input bit start_in_done);
    bit got;
    int fd0;
    fb        = f;
    exp_blk   = 0;
    frame_sum = 0;
    seen      = '0;
    ndist     = 0;
    cur_salt  = f * 7;
    fd0       = n_fd;
    sb_on     = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      start = (poke_busy && c == 40);
      if (frame_done) begin
        got   = 1'b1;
        start = start_in_done;
      end
    end
    chk("frame_done_seen", got, 1);
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_after_done", busy, 0);
    chk("frame_done_once", n_fd - fd0, 1);
  endtask

  initial begin
    bit hit;
    int nwr;
    vecs[0] = mkv(50, 40, 30, 30, 90, 60, 70, 80, 0, 0, 2);
    vecs[1] = mkv(100, 100, 100, 100, 100, 100, 100, 100, 0, 0, 0);
    vecs[2] = mkv(4095, 4095, 4095, 4095, 4095, 4095, 4095, 4094, 0, 0, 7);
    vecs[3] = mkv(9, 9, 9, 0, 9, 0, 9, 9, 0, 0, 3);
    vecs[4] = mkv(10, 20, 30, 40, 50, 60, 70, 5, 7, 0, 7);
    vecs[5] = mkv(800, 12, 700, 12, 3, 3, 900, 4, 2, 1, 4);
    vecs[6] = mkv(30, 20, 10, 5, 2, 1, 0, 0, 0, 0, 6);
    vecs[7] = mkv(5, 4, 3, 2, 1, 0, 1, 2, 1, 0, 5);
    cur_vec   = vecs[0];
    reset     = 1'b0;
    start     = 1'b0;
    wr_ready  = 1'b1;
    pred_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, pred_start, wr_en, mode_we, frame_done,
                        wr_addr, pred_blk, sad_idx, res_idx, res_mode}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Full frame, d=0, comparator edge vectors; 104-cycle frame.
    run_frame(0, 0, 0);
    // Slow predictor, back-pressure, start while busy and in DONE.
    run_frame(4, 1, 1);

    // Reset in the middle of a WRITE phase.
    fb = 0; exp_blk = 0; frame_sum = 0; cur_salt = 0; sb_on = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (wr_en && res_idx == 4'd4) hit = 1'b1;
    end
    chk("reached_write", hit, 1);
    #3 reset = 1'b0;
    sb_on = 1'b0;
    #1;
    chk("reset_mid_outputs", {busy, pred_start, wr_en, mode_we, frame_done,
                              wr_addr, pred_blk, sad_idx, res_idx, res_mode}, 0);
    wq.delete();
    mq.delete();
    cmp_chk_cyc = -1;
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    nwr = 0;
    repeat (30) begin
      @(negedge clk);
      if (wr_en || busy) nwr++;
    end
    chk("quiet_after_reset", nwr, 0);

    // Fresh start replays from block 0.
    run_frame(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
